// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter.
// Takes a WIDTH-bit word on a valid/ready handshake and shifts it out one bit
// per clock on serial_out, with serial_valid marking every frame bit.
// Back-to-back frames are sent with no idle cycle between them.
// Optional feature: define PISO_PARITY_EN to append one even-parity bit
// after the data bits, so frames become WIDTH+1 bits long.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             last_bit;
`ifdef PISO_PARITY_EN
    logic             parity_bit;
`endif

    // Bit that leaves the word first, depending on the bit order.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its first bit consumed, moving the next bit into the exit slot.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign accept   = load_valid && load_ready;
    assign last_bit = (state == SHIFT) && (bit_cnt == LAST_CNT);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a frame ends either into a new frame or back to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = SHIFT;
            end
            SHIFT: begin
`ifdef PISO_PARITY_EN
                if (last_bit) state_next = PARITY;
`else
                if (last_bit) state_next = accept ? SHIFT : IDLE;
`endif
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_next = accept ? SHIFT : IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Output logic: ready and frame_done are asserted only in the final bit cycle of a frame (and ready also in IDLE).
    always_comb begin
        load_ready = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
`ifndef PISO_PARITY_EN
                if (last_bit) begin
                    load_ready = 1'b1;
                    frame_done = 1'b1;
                end
`endif
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                load_ready = 1'b1;
                frame_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Datapath: load on accept, shift during the frame, clear the line when the frame ends.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg        <= '0;
            bit_cnt      <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_bit   <= 1'b0;
`endif
        end else if (accept) begin
            shreg        <= shift_word(load_data);
            serial_out   <= first_bit(load_data);
            serial_valid <= 1'b1;
            bit_cnt      <= '0;
`ifdef PISO_PARITY_EN
            parity_bit   <= ^load_data;
`endif
        end else if (state == SHIFT && !last_bit) begin
            shreg      <= shift_word(shreg);
            serial_out <= first_bit(shreg);
            bit_cnt    <= bit_cnt + CNT_W'(1);
`ifdef PISO_PARITY_EN
        end else if (last_bit) begin
            serial_out <= parity_bit;
`endif
        end else begin
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: randomized and directed bench for piso_serializer.
// Two instances (MSB-first and LSB-first) share the same input stream and are
// compared every cycle against a queue-based model of the bits on the wire.
module tb_piso_serializer;

    localparam int W = 8;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [W-1:0] load_data = '0;
    logic         load_valid = 1'b0;

    logic ready_m, out_m, valid_m, done_m;
    logic ready_l, out_l, valid_l, done_l;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Expected bits on the wire: element 0 is the bit currently shown.
    bit qm[$];
    bit ql[$];

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk(clk), .reset_n(reset_n), .load_data(load_data), .load_valid(load_valid),
        .load_ready(ready_m), .serial_out(out_m), .serial_valid(valid_m), .frame_done(done_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset_n(reset_n), .load_data(load_data), .load_valid(load_valid),
        .load_ready(ready_l), .serial_out(out_l), .serial_valid(valid_l), .frame_done(done_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance the model across one rising edge using the inputs presented there.
    task automatic model_step();
        if (!reset_n) begin
            qm.delete();
            ql.delete();
        end else begin
            bit acc;
            acc = load_valid && (qm.size() <= 1);
            if (qm.size() > 0) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    qm.push_back(load_data[W-1-i]);
                    ql.push_back(load_data[i]);
                end
`ifdef PISO_PARITY_EN
                qm.push_back(^load_data);
                ql.push_back(^load_data);
`endif
            end
        end
    endtask

    // Present inputs, cross one rising edge, return at the following falling edge.
    task automatic cycle(input logic v, input logic [W-1:0] d);
        load_valid = v;
        load_data  = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid_msb", valid_m, qm.size() > 0);
            check("out_msb",   out_m,   (qm.size() > 0) ? qm[0] : 1'b0);
            check("done_msb",  done_m,  qm.size() == 1);
            check("ready_msb", ready_m, qm.size() <= 1);
            check("valid_lsb", valid_l, ql.size() > 0);
            check("out_lsb",   out_l,   (ql.size() > 0) ? ql[0] : 1'b0);
            check("done_lsb",  done_l,  ql.size() == 1);
            check("ready_lsb", ready_l, ql.size() <= 1);
        end
    end

    // Send one word and record the wire over its whole frame (first bit ends up in the MSB).
    // A stray load_valid with different data is pulsed mid-frame and must be ignored.
    task automatic send_capture(input logic [W-1:0] d, output logic [FL-1:0] cm,
                                output logic [FL-1:0] cl, output logic [FL-1:0] cd);
        cm = '0;
        cl = '0;
        cd = '0;
        for (int i = 0; i < FL; i++) begin
            cycle((i == 0) || (i == 3), (i == 0) ? d : W'($urandom));
            cm = {cm[FL-2:0], out_m};
            cl = {cl[FL-2:0], out_l};
            cd = {cd[FL-2:0], done_m};
        end
    endtask

    logic [FL-1:0]   cm, cl, cd;
    logic [2*FL-1:0] bb_out, bb_val, bb_rdy;
    logic [FL-1:0]   exp_a5, exp_01m, exp_01l;
    logic [2*FL-1:0] exp_bb;

    initial begin
`ifdef PISO_PARITY_EN
        exp_a5  = {8'hA5, 1'b0};
        exp_01m = {8'h01, 1'b1};
        exp_01l = {8'h80, 1'b1};
        exp_bb  = {8'hFF, 1'b0, 8'h00, 1'b0};
`else
        exp_a5  = 8'hA5;
        exp_01m = 8'h01;
        exp_01l = 8'h80;
        exp_bb  = 16'hFF00;
`endif
        // Power-on reset state.
        #1 reset_n = 1'b0;
        #1;
        check("rst_out",   out_m,   1'b0);
        check("rst_valid", valid_m, 1'b0);
        check("rst_done",  done_m,  1'b0);
        check("rst_ready", ready_m, 1'b1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk_en = 1'b1;
        cycle(0, '0);
        cycle(0, '0);

        // 8'hA5: same bit sequence in both orders (palindrome), done only on the last bit.
        send_capture(8'hA5, cm, cl, cd);
        check("a5_msb_bits", cm, exp_a5);
        check("a5_lsb_bits", cl, exp_a5);
        check("a5_done",     cd, 1);
        cycle(0, '0);
        check("a5_valid_drop", valid_m, 1'b0);

        // 8'h01: a single 1 at opposite ends of the frame depending on order.
        send_capture(8'h01, cm, cl, cd);
        check("x01_msb_bits", cm, exp_01m);
        check("x01_lsb_bits", cl, exp_01l);
        cycle(0, '0);
        check("x01_valid_drop", valid_l, 1'b0);

`ifdef PISO_PARITY_EN
        send_capture(8'h07, cm, cl, cd);
        check("x07_parity", cm, {8'h07, 1'b1});
        check("x07_done",   cd, 1);
        cycle(0, '0);
        send_capture(8'h03, cm, cl, cd);
        check("x03_parity", cm, {8'h03, 1'b0});
        cycle(0, '0);
`endif

        // Back-to-back: load_valid held high, 8'hFF then 8'h00, no gap.
        bb_out = '0;
        bb_val = '0;
        bb_rdy = '0;
        for (int i = 0; i < 2 * FL; i++) begin
            cycle(i <= FL, (i == 0) ? 8'hFF : 8'h00);
            bb_out = {bb_out[2*FL-2:0], out_m};
            bb_val = {bb_val[2*FL-2:0], valid_m};
            bb_rdy = {bb_rdy[2*FL-2:0], ready_m};
        end
        check("bb_bits",  bb_out, exp_bb);
        check("bb_valid", bb_val, {(2*FL){1'b1}});
        check("bb_ready", bb_rdy, (2*FL)'((1 << FL) | 1));
        cycle(0, '0);
        check("bb_valid_drop", valid_m, 1'b0);

        // Reset asserted mid-frame clears the line without a clock edge.
        cycle(1, 8'hFF);
        cycle(0, '0);
        cycle(0, '0);
        #2 reset_n = 1'b0;
        #1;
        qm.delete();
        ql.delete();
        check("midrst_out",   out_m,   1'b0);
        check("midrst_valid", valid_m, 1'b0);
        check("midrst_lsb_v", valid_l, 1'b0);
        check("midrst_ready", ready_m, 1'b1);
        cycle(0, '0);
        cycle(1, 8'h5A);
        #2 reset_n = 1'b1;
        repeat (3) cycle(0, '0);

        // Randomized traffic with data changing every cycle.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 60, W'($urandom));
        end
        repeat (FL + 2) cycle(0, '0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
